// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and buffers
// {pc, instr, misaligned} in a small FIFO toward decode, with redirect/flush support.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_misaligned
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, FAULT, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fault_pc;

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic            mem_mis   [DEPTH];

  logic            pop;
  logic            run_push;
  logic            fault_push;
  logic            push;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_instr;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // A full FIFO can still accept a new word when the head leaves in the same cycle.
  assign run_push   = (state == RUN) & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
  assign fault_push = (state == FAULT) & ~redirect_valid;
  assign push       = run_push | fault_push;
  assign push_pc    = fault_push ? fault_pc : pc;
  assign push_instr = fault_push ? NOP : imem_instr;

  assign out_pc         = out_valid ? mem_pc[head]    : '0;
  assign out_instr      = out_valid ? mem_instr[head] : '0;
  assign out_misaligned = out_valid ? mem_mis[head]   : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc    <= redirect_pc;
        state <= RUN;
      end else begin
        // Fetch address stays word aligned; the faulting target is kept for the fault entry.
        pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        fault_pc <= redirect_pc;
        state    <= FAULT;
      end
    end else begin
      case (state)
        RUN: begin
          if (run_push) pc <= pc + XLEN'(4);
        end
        FAULT:   state <= HALT;
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= push_pc;
      mem_instr[tail] <= push_instr;
      mem_mis[tail]   <= fault_push;
    end
  end

`ifndef SYNTHESIS
  pc_aligned: assert property (@(posedge clk) disable iff (rst) pc[1:0] == 2'b00);
`endif

endmodule
